// File: rtl/riscv_defines.sv
// Shared types and opcode constants for the multicycle RV32I control path.
package riscv_defines;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecuteR, StExecuteI,
    StAluWb, StJal, StJalr, StBranch, StLui, StAuipc, StTrap
  } FsmState_t;

  typedef enum logic [1:0] {SrcAPc, SrcAOldPc, SrcARs1, SrcAZero} AluSrcA_t;
  typedef enum logic [1:0] {SrcBRs2, SrcBImm, SrcBFour} AluSrcB_t;
  typedef enum logic [1:0] {AluOpAdd, AluOpBranch, AluOpFunct} AluOp_t;
  typedef enum logic [1:0] {ResAluOut, ResData, ResAluResult, ResCsr} ResultSrc_t;

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  typedef struct packed {
    logic       mem_valid;
    logic       mem_wr;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       trap;
    AluSrcA_t   alu_src_a;
    AluSrcB_t   alu_src_b;
    AluOp_t     alu_op;
    ResultSrc_t result_src;
  } ctrl_t;

endpackage

// File: rtl/multicycle_fsm_outputs.sv
// State-to-control decode for the multicycle controller; everything is forced to 0 when en_i is low.
module multicycle_fsm_outputs
  import riscv_defines::*;
(
  input  FsmState_t  state_i,
  input  logic       en_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  input  logic [6:0] op_i,
  output ctrl_t      ctrl_o
);

  logic is_system;
  assign is_system = (op_i == OpSystem);

  always_comb begin
    ctrl_o = '0;
    if (en_i) begin
      case (state_i)
        StFetch: begin
          ctrl_o.mem_valid  = 1'b1;
          ctrl_o.ir_write   = mem_ready_i;
          ctrl_o.pc_update  = mem_ready_i;
          ctrl_o.alu_src_a  = SrcAPc;
          ctrl_o.alu_src_b  = SrcBFour;
          ctrl_o.result_src = ResAluResult;
        end
        StDecode: begin
          ctrl_o.alu_src_a = SrcAOldPc;
          ctrl_o.alu_src_b = SrcBImm;
        end
        StMemAdr, StJalr: begin
          ctrl_o.alu_src_a = SrcARs1;
          ctrl_o.alu_src_b = SrcBImm;
        end
        StMemRead: begin
          ctrl_o.mem_valid = 1'b1;
          ctrl_o.adr_src   = 1'b1;
        end
        StMemWb: begin
          ctrl_o.result_src = ResData;
          ctrl_o.reg_write  = 1'b1;
        end
        StMemWrite: begin
          ctrl_o.mem_valid = 1'b1;
          ctrl_o.mem_wr    = 1'b1;
          ctrl_o.adr_src   = 1'b1;
        end
        StExecuteR, StExecuteI: begin
          ctrl_o.alu_src_a  = SrcARs1;
          ctrl_o.alu_src_b  = (state_i == StExecuteI) ? SrcBImm : SrcBRs2;
          ctrl_o.alu_op     = AluOpFunct;
          ctrl_o.result_src = is_system ? ResCsr : ResAluOut;
        end
        StAluWb: begin
          ctrl_o.result_src = is_system ? ResCsr : ResAluOut;
          ctrl_o.reg_write  = 1'b1;
        end
        StJal: begin
          ctrl_o.pc_update = 1'b1;
          ctrl_o.alu_src_a = SrcAOldPc;
          ctrl_o.alu_src_b = SrcBFour;
        end
        StBranch: begin
          ctrl_o.alu_src_a = SrcARs1;
          ctrl_o.alu_op    = AluOpBranch;
          ctrl_o.branch    = 1'b1;
          ctrl_o.pc_update = ~zero_i;  // Zero==0 means taken
        end
        StLui: begin
          ctrl_o.alu_src_a = SrcAZero;
          ctrl_o.alu_src_b = SrcBImm;
        end
        StAuipc: begin
          ctrl_o.alu_src_a = SrcAOldPc;
          ctrl_o.alu_src_b = SrcBImm;
        end
        StTrap:  ctrl_o.trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencer: state register, next-state logic and retired-instruction counter.
module multicycle_control_fsm
  import riscv_defines::*;
#(
  parameter int unsigned INSTRET_WIDTH   = 64,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               op,
  input  logic [2:0]               funct3,
  input  logic                     Zero,
  input  logic                     mem_ready,
  output logic                     mem_valid,
  output logic                     mem_wr,
  output logic                     AdrSrc,
  output logic                     IRWrite,
  output logic                     PCUpdate,
  output logic                     Branch,
  output logic                     RegWrite,
  output AluSrcA_t                 AluSrcA,
  output AluSrcB_t                 AluSrcB,
  output AluOp_t                   AluOp,
  output ResultSrc_t               ResultSrc,
  output logic                     instr_retired,
  output logic [INSTRET_WIDTH-1:0] instret,
  output logic                     trap
);

  FsmState_t                state_q, state_d;
  logic                     retire_d, retired_q;
  logic [INSTRET_WIDTH-1:0] instret_q;
  ctrl_t                    ctrl;
  logic                     unused_funct3;

  assign unused_funct3 = ^funct3;

  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore:  state_d = StMemAdr;
          OpOp, OpSystem:   state_d = StExecuteR;
          OpOpImm:          state_d = StExecuteI;
          OpJal:            state_d = StJal;
          OpJalr:           state_d = StJalr;
          OpBranch:         state_d = StBranch;
          OpLui:            state_d = StLui;
          OpAuipc:          state_d = StAuipc;
          OpMiscMem: begin
            state_d  = StFetch;
            retire_d = 1'b1;
          end
          default:          state_d = HALT_ON_ILLEGAL ? StTrap : StFetch;
        endcase
      end
      StMemAdr:  state_d = op[5] ? StMemWrite : StMemRead;
      StMemRead: if (mem_ready) state_d = StMemWb;
      StMemWrite: begin
        if (mem_ready) begin
          state_d  = StFetch;
          retire_d = 1'b1;
        end
      end
      StMemWb, StAluWb, StBranch: begin
        state_d  = StFetch;
        retire_d = 1'b1;
      end
      StExecuteR, StExecuteI, StJal, StLui, StAuipc: state_d = StAluWb;
      StJalr:    state_d = StJal;
      StTrap:    state_d = StTrap;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      retired_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retire_d;
      if (retire_d) instret_q <= instret_q + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Gating with rst keeps FETCH's request low while reset is still asserted.
  multicycle_fsm_outputs u_outputs (
    .state_i     (state_q),
    .en_i        (~rst),
    .mem_ready_i (mem_ready),
    .zero_i      (Zero),
    .op_i        (op),
    .ctrl_o      (ctrl)
  );

  assign mem_valid     = ctrl.mem_valid;
  assign mem_wr        = ctrl.mem_wr;
  assign AdrSrc        = ctrl.adr_src;
  assign IRWrite       = ctrl.ir_write;
  assign PCUpdate      = ctrl.pc_update;
  assign Branch        = ctrl.branch;
  assign RegWrite      = ctrl.reg_write;
  assign AluSrcA       = ctrl.alu_src_a;
  assign AluSrcB       = ctrl.alu_src_b;
  assign AluOp         = ctrl.alu_op;
  assign ResultSrc     = ctrl.result_src;
  assign trap          = ctrl.trap;
  assign instr_retired = retired_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: vector table, directed corner cases, randomized instruction stream.
module tb_multicycle_control_fsm;
  import riscv_defines::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic a_mem_valid, a_mem_wr, a_AdrSrc, a_IRWrite, a_PCUpdate, a_Branch, a_RegWrite;
  logic a_instr_retired, a_trap;
  AluSrcA_t a_AluSrcA;  AluSrcB_t a_AluSrcB;  AluOp_t a_AluOp;  ResultSrc_t a_ResultSrc;
  logic [63:0] a_instret;

  logic b_mem_valid, b_mem_wr, b_AdrSrc, b_IRWrite, b_PCUpdate, b_Branch, b_RegWrite;
  logic b_instr_retired, b_trap;
  AluSrcA_t b_AluSrcA;  AluSrcB_t b_AluSrcB;  AluOp_t b_AluOp;  ResultSrc_t b_ResultSrc;
  logic [3:0] b_instret;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut_a (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .Zero(Zero), .mem_ready(mem_ready),
    .mem_valid(a_mem_valid), .mem_wr(a_mem_wr), .AdrSrc(a_AdrSrc), .IRWrite(a_IRWrite),
    .PCUpdate(a_PCUpdate), .Branch(a_Branch), .RegWrite(a_RegWrite), .AluSrcA(a_AluSrcA),
    .AluSrcB(a_AluSrcB), .AluOp(a_AluOp), .ResultSrc(a_ResultSrc),
    .instr_retired(a_instr_retired), .instret(a_instret), .trap(a_trap)
  );

  multicycle_control_fsm #(.INSTRET_WIDTH(4), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .Zero(Zero), .mem_ready(mem_ready),
    .mem_valid(b_mem_valid), .mem_wr(b_mem_wr), .AdrSrc(b_AdrSrc), .IRWrite(b_IRWrite),
    .PCUpdate(b_PCUpdate), .Branch(b_Branch), .RegWrite(b_RegWrite), .AluSrcA(b_AluSrcA),
    .AluSrcB(b_AluSrcB), .AluOp(b_AluOp), .ResultSrc(b_ResultSrc),
    .instr_retired(b_instr_retired), .instret(b_instret), .trap(b_trap)
  );

  function automatic logic [14:0] pk(input logic mv, mw, adr, irw, pcu, br, rw,
                                     input AluSrcA_t a, input AluSrcB_t b, input AluOp_t o,
                                     input ResultSrc_t r);
    return {mv, mw, adr, irw, pcu, br, rw, a, b, o, r};
  endfunction

  logic [14:0] a_ctl;
  assign a_ctl = pk(a_mem_valid, a_mem_wr, a_AdrSrc, a_IRWrite, a_PCUpdate, a_Branch,
                    a_RegWrite, a_AluSrcA, a_AluSrcB, a_AluOp, a_ResultSrc);

  typedef struct {
    logic        rdy;
    logic [6:0]  op;
    logic        zero;
    logic [14:0] ctl;
    logic        ret;
    logic [63:0] cnt;
  } vec_t;
  vec_t vt[$];

  task automatic add_vec(input logic r, input logic [6:0] o, input logic z,
                         input logic [14:0] c, input logic rt, input logic [63:0] n);
    vec_t v;
    v.rdy = r; v.op = o; v.zero = z; v.ctl = c; v.ret = rt; v.cnt = n;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench at posedge+1 with reset just released.
  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ctl", a_ctl, '0);
    chk("reset instret", a_instret, 0);
    chk("reset trap", a_trap, 0);
    chk("reset retired", a_instr_retired, 0);
    rst = 1'b0;
  endtask

  // Spec-level view of one instruction after its fetch completes.
  int e_act, e_rw, e_rd, e_wr, e_pcu;
  bit e_ret;
  ResultSrc_t e_res;
  logic [6:0] ops [11] = '{OpLoad, OpStore, OpOp, OpOpImm, OpJal, OpJalr, OpBranch, OpLui,
                           OpAuipc, OpMiscMem, OpSystem};

  task automatic pick_instr();
    int k;
    k = $urandom_range(0, 11);
    op = (k == 11) ? 7'($urandom) : ops[k];
    Zero = 1'($urandom_range(0, 1));
    funct3 = 3'($urandom);
    e_act = 3; e_rw = 0; e_rd = 0; e_wr = 0; e_pcu = 0; e_ret = 1'b1; e_res = ResAluOut;
    case (op)
      OpLoad:   begin e_act = 4; e_rw = 1; e_rd = 1; e_res = ResData; end
      OpStore:  e_wr = 1;
      OpOp, OpOpImm, OpLui, OpAuipc: e_rw = 1;
      OpSystem: begin e_rw = 1; e_res = ResCsr; end
      OpJal:    begin e_rw = 1; e_pcu = 1; end
      OpJalr:   begin e_act = 4; e_rw = 1; e_pcu = 1; end
      OpBranch: begin e_act = 2; e_pcu = Zero ? 0 : 1; end
      OpMiscMem: e_act = 1;
      default:  begin e_act = 1; e_ret = 1'b0; end
    endcase
  endtask

  bit rdy_p [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
  bit mv_p  [10] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
  bit adr_p [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete (%0d vectors so far)", n_vec);
    $fatal(1);
  end

  initial begin
    logic [14:0] c_fetch, c_dec, c_madr;
    int cnt, trap_mv;
    int a_cnt, r_rw, r_rd, r_wr, r_pcu, r_bad, ninstr, model_cnt, model_ret, pulses;
    bit in_exec, newfetch;

    c_fetch = pk(1, 0, 0, 1, 1, 0, 0, SrcAPc, SrcBFour, AluOpAdd, ResAluResult);
    c_dec   = pk(0, 0, 0, 0, 0, 0, 0, SrcAOldPc, SrcBImm, AluOpAdd, ResAluOut);
    c_madr  = pk(0, 0, 0, 0, 0, 0, 0, SrcARs1, SrcBImm, AluOpAdd, ResAluOut);

    add_vec(1, OpOpImm, 0, c_fetch, 0, 0);
    add_vec(0, OpOpImm, 0, c_dec, 0, 0);
    add_vec(0, OpOpImm, 0, pk(0, 0, 0, 0, 0, 0, 0, SrcARs1, SrcBImm, AluOpFunct, ResAluOut), 0, 0);
    add_vec(0, OpOpImm, 0, pk(0, 0, 0, 0, 0, 0, 1, SrcAPc, SrcBRs2, AluOpAdd, ResAluOut), 0, 0);
    add_vec(1, OpLoad, 0, c_fetch, 1, 1);
    add_vec(0, OpLoad, 0, c_dec, 0, 1);
    add_vec(0, OpLoad, 0, c_madr, 0, 1);
    add_vec(1, OpLoad, 0, pk(1, 0, 1, 0, 0, 0, 0, SrcAPc, SrcBRs2, AluOpAdd, ResAluOut), 0, 1);
    add_vec(0, OpLoad, 0, pk(0, 0, 0, 0, 0, 0, 1, SrcAPc, SrcBRs2, AluOpAdd, ResData), 0, 1);
    add_vec(1, OpStore, 0, c_fetch, 1, 2);
    add_vec(0, OpStore, 0, c_dec, 0, 2);
    add_vec(0, OpStore, 0, c_madr, 0, 2);
    add_vec(1, OpStore, 0, pk(1, 1, 1, 0, 0, 0, 0, SrcAPc, SrcBRs2, AluOpAdd, ResAluOut), 0, 2);
    add_vec(1, OpBranch, 0, c_fetch, 1, 3);
    add_vec(0, OpBranch, 0, c_dec, 0, 3);
    add_vec(0, OpBranch, 0, pk(0, 0, 0, 0, 1, 1, 0, SrcARs1, SrcBRs2, AluOpBranch, ResAluOut), 0, 3);
    add_vec(1, OpBranch, 1, c_fetch, 1, 4);
    add_vec(0, OpBranch, 1, c_dec, 0, 4);
    add_vec(0, OpBranch, 1, pk(0, 0, 0, 0, 0, 1, 0, SrcARs1, SrcBRs2, AluOpBranch, ResAluOut), 0, 4);
    add_vec(1, OpJal, 0, c_fetch, 1, 5);
    add_vec(0, OpJal, 0, c_dec, 0, 5);
    add_vec(0, OpJal, 0, pk(0, 0, 0, 0, 1, 0, 0, SrcAOldPc, SrcBFour, AluOpAdd, ResAluOut), 0, 5);
    add_vec(0, OpJal, 0, pk(0, 0, 0, 0, 0, 0, 1, SrcAPc, SrcBRs2, AluOpAdd, ResAluOut), 0, 5);
    add_vec(1, OpMiscMem, 0, c_fetch, 1, 6);
    add_vec(0, OpMiscMem, 0, c_dec, 0, 6);
    add_vec(1, OpLui, 0, c_fetch, 1, 7);
    add_vec(0, OpLui, 0, c_dec, 0, 7);
    add_vec(0, OpLui, 0, pk(0, 0, 0, 0, 0, 0, 0, SrcAZero, SrcBImm, AluOpAdd, ResAluOut), 0, 7);
    add_vec(0, OpLui, 0, pk(0, 0, 0, 0, 0, 0, 1, SrcAPc, SrcBRs2, AluOpAdd, ResAluOut), 0, 7);
    add_vec(1, OpLui, 0, c_fetch, 1, 8);

    do_reset();
    foreach (vt[i]) begin
      mem_ready = vt[i].rdy; op = vt[i].op; Zero = vt[i].zero;
      #2;
      chk($sformatf("vec%0d ctl", i), a_ctl, vt[i].ctl);
      chk($sformatf("vec%0d retired", i), a_instr_retired, vt[i].ret);
      chk($sformatf("vec%0d instret", i), a_instret, vt[i].cnt);
      @(posedge clk); #1;
    end

    // LW with 3 fetch wait cycles and 2 read wait cycles: 10 cycles total
    do_reset();
    op = OpLoad; Zero = 1'b0; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy_p[i];
      #2;
      chk($sformatf("lw-wait c%0d mem_valid", i), a_mem_valid, mv_p[i]);
      if (mv_p[i]) chk($sformatf("lw-wait c%0d AdrSrc", i), a_AdrSrc, adr_p[i]);
      if (a_RegWrite && a_ResultSrc == ResData) cnt++;
      @(posedge clk); #1;
    end
    chk("lw-wait data writebacks", cnt, 1);
    mem_ready = 1'b0;
    #2;
    chk("lw-wait next fetch", {a_mem_valid, a_AdrSrc}, 2'b10);
    chk("lw-wait retired", a_instr_retired, 1);
    chk("lw-wait instret", a_instret, 1);
    @(posedge clk); #1;

    // Illegal opcode: dut_a halts in TRAP, dut_b skips it
    do_reset();
    op = 7'b0000000;
    mem_ready = 1'b1; @(posedge clk); #1;
    mem_ready = 1'b0; @(posedge clk); #1;
    #2;
    chk("illegal skip fetch", {b_mem_valid, b_AdrSrc}, 2'b10);
    chk("illegal skip instret", b_instret, 0);
    chk("illegal skip trap", b_trap, 0);
    chk("illegal skip retired", b_instr_retired, 0);
    trap_mv = 0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("trap c%0d", i), a_trap, 1);
      if (a_mem_valid) trap_mv++;
      @(posedge clk); #1;
      mem_ready = 1'($urandom_range(0, 1));
      #2;
    end
    chk("trap mem_valid cycles", trap_mv, 0);
    chk("trap instret", a_instret, 0);

    // Reset asserted while a store waits on memory
    do_reset();
    op = OpStore;
    mem_ready = 1'b1; @(posedge clk); #1;
    mem_ready = 1'b0; @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    chk("sw-rst pending", {a_mem_valid, a_mem_wr, a_AdrSrc}, 3'b111);
    rst = 1'b1;
    #1;
    chk("sw-rst mem_valid drop", a_mem_valid, 0);
    chk("sw-rst regwrite", a_RegWrite, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("sw-rst refetch", {a_mem_valid, a_mem_wr, a_AdrSrc}, 3'b100);
    chk("sw-rst instret", a_instret, 0);
    @(posedge clk); #1;

    // Random instruction stream on dut_b against the per-instruction model
    do_reset();
    pick_instr();
    in_exec = 1'b0; newfetch = 1'b1; ninstr = 0; model_cnt = 0; model_ret = 0; pulses = 0;
    a_cnt = 0; r_rw = 0; r_rd = 0; r_wr = 0; r_pcu = 0; r_bad = 0;
    for (int cyc = 0; cyc < 6000 && ninstr < 150; cyc++) begin
      mem_ready = ($urandom_range(0, 2) != 0);
      #2;
      if (b_mem_valid && !b_AdrSrc) begin
        if (in_exec) begin
          chk($sformatf("rnd%0d op=%b cycles", ninstr, op), a_cnt, e_act);
          chk($sformatf("rnd%0d op=%b regwrites", ninstr, op), r_rw, e_rw);
          chk($sformatf("rnd%0d op=%b reads", ninstr, op), r_rd, e_rd);
          chk($sformatf("rnd%0d op=%b writes", ninstr, op), r_wr, e_wr);
          chk($sformatf("rnd%0d op=%b pcupdates", ninstr, op), r_pcu, e_pcu);
          chk($sformatf("rnd%0d op=%b bad resultsrc", ninstr, op), r_bad, 0);
          if (e_ret) begin model_cnt++; model_ret++; end
          ninstr++;
          in_exec = 1'b0;
          newfetch = 1'b1;
          pick_instr();
        end
        if (newfetch) begin
          chk($sformatf("rnd%0d instret", ninstr), b_instret, 64'(model_cnt % 16));
          newfetch = 1'b0;
        end
        if (b_IRWrite) begin
          in_exec = 1'b1;
          a_cnt = 0; r_rw = 0; r_rd = 0; r_wr = 0; r_pcu = 0; r_bad = 0;
        end
      end else if (in_exec) begin
        if (!(b_mem_valid && !mem_ready)) a_cnt++;
        if (b_RegWrite) begin
          r_rw++;
          if (b_ResultSrc != e_res) r_bad++;
        end
        if (b_mem_valid && mem_ready && !b_mem_wr) r_rd++;
        if (b_mem_valid && mem_ready && b_mem_wr) r_wr++;
        if (b_PCUpdate) r_pcu++;
      end
      if (b_instr_retired) pulses++;
      @(posedge clk); #1;
    end
    chk("rnd instructions completed", ninstr, 150);
    chk("rnd retire pulses", pulses, model_ret);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
